// File: rtl/pll_seq_pkg.sv
// Shared state encoding and saturating counter helper for the PLL reset sequencer.
package pll_seq_pkg;

   typedef enum logic [2:0] {
      RESET_PLL,
      WAIT_LOCK,
      STABLE,
      RELEASE,
      RUN
   } seq_state_t;

   function automatic logic [7:0] sat_inc8(input logic [7:0] v);
      return (v == 8'hFF) ? v : v + 8'd1;
   endfunction

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for the asynchronous PLL LOCK input.
module sync2 (
   input  logic clock,
   input  logic reset,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clock) begin
      if (reset) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// Drives PLL RESETB, qualifies LOCK, then releases staged system resets in order.
// Runs on the board reference clock so it keeps working while the PLL is down.
module pll_reset_sequencer
   import pll_seq_pkg::*;
#(
   parameter int PLL_RST_CYCLES = 16,
   parameter int LOCK_TIMEOUT   = 65535,
   parameter int STABLE_CYCLES  = 1024,
   parameter int NSTAGES        = 3,
   parameter int STAGE_GAP      = 16
) (
   input  logic               clock,
   input  logic               reset,
   input  logic               pll_lock,
   input  logic               relock_req,
   output logic               pll_resetb,
   output logic [NSTAGES-1:0] stage_reset,
   output logic               locked,
   output logic [7:0]         retry_count,
   output logic [7:0]         lost_count
);

   localparam int M_A  = (PLL_RST_CYCLES > LOCK_TIMEOUT) ? PLL_RST_CYCLES : LOCK_TIMEOUT;
   localparam int M_B  = (STABLE_CYCLES > STAGE_GAP) ? STABLE_CYCLES : STAGE_GAP;
   localparam int CMAX = (M_A > M_B) ? M_A : M_B;
   localparam int CW   = $clog2(CMAX) + 1;
   localparam int SW   = (NSTAGES > 1) ? $clog2(NSTAGES) : 1;

   seq_state_t    state;
   logic [CW-1:0] cnt;
   logic [SW-1:0] idx;
   logic          lock_s;
   logic          lock_lost;
   logic          timeout;
   logic          restart;

   sync2 u_lock_sync (
      .clock (clock),
      .reset (reset),
      .d     (pll_lock),
      .q     (lock_s)
   );

   // Lock loss takes priority over relock so a coincident loss is still counted.
   assign lock_lost = !lock_s && (state == RELEASE || state == RUN);
   assign timeout   = (state == WAIT_LOCK) && !lock_s && (cnt == '0);
   assign restart   = lock_lost || timeout || (relock_req && state != RESET_PLL);

   always_ff @(posedge clock) begin
      if (reset) begin
         state       <= RESET_PLL;
         cnt         <= CW'(PLL_RST_CYCLES - 1);
         idx         <= '0;
         pll_resetb  <= 1'b0;
         stage_reset <= '1;
         locked      <= 1'b0;
         retry_count <= 8'd0;
         lost_count  <= 8'd0;
      end else if (restart) begin
         state       <= RESET_PLL;
         cnt         <= CW'(PLL_RST_CYCLES - 1);
         idx         <= '0;
         pll_resetb  <= 1'b0;
         stage_reset <= '1;
         locked      <= 1'b0;
         if (lock_lost)
            lost_count <= sat_inc8(lost_count);
         if (timeout && !relock_req)
            retry_count <= sat_inc8(retry_count);
      end else begin
         case (state)
            RESET_PLL: begin
               if (cnt == '0) begin
                  state      <= WAIT_LOCK;
                  cnt        <= CW'(LOCK_TIMEOUT - 1);
                  pll_resetb <= 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            WAIT_LOCK: begin
               if (lock_s) begin
                  state <= STABLE;
                  cnt   <= CW'(STABLE_CYCLES - 1);
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            STABLE: begin
               if (!lock_s) begin
                  state <= WAIT_LOCK;
                  cnt   <= CW'(LOCK_TIMEOUT - 1);
               end else if (cnt == '0) begin
                  stage_reset[0] <= 1'b0;
                  idx            <= SW'(1);
                  cnt            <= CW'(STAGE_GAP - 1);
                  state          <= (NSTAGES == 1) ? RUN : RELEASE;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RELEASE: begin
               // lock_s is known high here; loss is handled by restart.
               if (cnt == '0) begin
                  stage_reset[idx] <= 1'b0;
                  cnt              <= CW'(STAGE_GAP - 1);
                  if (idx == SW'(NSTAGES - 1))
                     state <= RUN;
                  else
                     idx <= idx + 1'b1;
               end else begin
                  cnt <= cnt - 1'b1;
               end
            end
            RUN: begin
               locked <= 1'b1;
            end
            default: begin
               state <= RESET_PLL;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed and randomized checks of the PLL reset sequencer against a cycle-level behavioural model.
module tb_pll_reset_sequencer;

   localparam int PR  = 4;
   localparam int TO  = 50;
   localparam int ST  = 8;
   localparam int NS  = 3;
   localparam int GAP = 3;

   localparam int P_RST  = 0;
   localparam int P_WAIT = 1;
   localparam int P_STAB = 2;
   localparam int P_REL  = 3;
   localparam int P_RUN  = 4;

   logic          clock = 1'b0;
   logic          reset = 1'b1;
   logic          pll_lock = 1'b0;
   logic          relock_req = 1'b0;
   logic          pll_resetb;
   logic [NS-1:0] stage_reset;
   logic          locked;
   logic [7:0]    retry_count;
   logic [7:0]    lost_count;

   int checks = 0;
   int failures = 0;
   int cyc = 0;

   // Model: phase, cycles spent in phase, stages released, synchroniser image.
   int   ph = P_RST;
   int   t = 0;
   int   rel = 0;
   int   m_retry = 0;
   int   m_lost = 0;
   logic m_resetb = 1'b0;
   logic m_locked = 1'b0;
   logic s1 = 1'b0;
   logic s2 = 1'b0;

   pll_reset_sequencer #(
      .PLL_RST_CYCLES (PR),
      .LOCK_TIMEOUT   (TO),
      .STABLE_CYCLES  (ST),
      .NSTAGES        (NS),
      .STAGE_GAP      (GAP)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .pll_lock    (pll_lock),
      .relock_req  (relock_req),
      .pll_resetb  (pll_resetb),
      .stage_reset (stage_reset),
      .locked      (locked),
      .retry_count (retry_count),
      .lost_count  (lost_count)
   );

   always #5 clock = ~clock;

   function automatic logic [31:0] obs_vec();
      return {11'd0, pll_resetb, stage_reset, locked, retry_count, lost_count};
   endfunction

   function automatic logic [31:0] exp_vec(input logic rb, input logic [NS-1:0] st,
                                           input logic lk, input int rc, input int lc);
      return {11'd0, rb, st, lk, rc[7:0], lc[7:0]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
      end
   endtask

   task automatic go_rst();
      ph = P_RST;
      t = 0;
      rel = 0;
      m_resetb = 1'b0;
      m_locked = 1'b0;
   endtask

   task automatic model_step();
      logic ls;
      ls = s2;
      s2 = s1;
      s1 = pll_lock;
      if (reset) begin
         go_rst();
         m_retry = 0;
         m_lost = 0;
         s1 = 1'b0;
         s2 = 1'b0;
         return;
      end
      case (ph)
         P_RST: begin
            if (t == PR - 1) begin ph = P_WAIT; t = 0; m_resetb = 1'b1; end
            else t++;
         end
         P_WAIT: begin
            if (relock_req) go_rst();
            else if (ls) begin ph = P_STAB; t = 0; end
            else if (t == TO - 1) begin
               m_retry = (m_retry < 255) ? m_retry + 1 : 255;
               go_rst();
            end else t++;
         end
         P_STAB: begin
            if (relock_req) go_rst();
            else if (!ls) begin ph = P_WAIT; t = 0; end
            else if (t == ST - 1) begin
               t = 0;
               rel = 1;
               ph = (rel == NS) ? P_RUN : P_REL;
            end else t++;
         end
         P_REL: begin
            if (!ls) begin m_lost = (m_lost < 255) ? m_lost + 1 : 255; go_rst(); end
            else if (relock_req) go_rst();
            else begin
               t++;
               rel = 1 + t / GAP;
               if (rel >= NS) begin rel = NS; ph = P_RUN; end
            end
         end
         default: begin
            if (!ls) begin m_lost = (m_lost < 255) ? m_lost + 1 : 255; go_rst(); end
            else if (relock_req) go_rst();
            else m_locked = 1'b1;
         end
      endcase
   endtask

   task automatic tick();
      logic [NS-1:0] full;
      @(posedge clock);
      model_step();
      cyc++;
      @(negedge clock);
      full = '1;
      chk("cycle", obs_vec(), exp_vec(m_resetb, full << rel, m_locked, m_retry, m_lost));
   endtask

   task automatic do_reset();
      reset = 1'b1;
      relock_req = 1'b0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      bit found;

      // 1: clean bring-up, lock at cycle 10
      pll_lock = 1'b0;
      do_reset();
      chk("reset_state", obs_vec(), exp_vec(1'b0, 3'b111, 1'b0, 0, 0));
      for (int e = 1; e <= 27; e++) begin
         if (e == 10) pll_lock = 1'b1;
         tick();
         case (e)
            3:  chk("s1_resetb_low", 32'(pll_resetb), 32'd0);
            4:  chk("s1_resetb_high", 32'(pll_resetb), 32'd1);
            19: chk("s1_hold_111", 32'(stage_reset), 32'b111);
            20: chk("s1_stage0", 32'(stage_reset), 32'b110);
            22: chk("s1_gap", 32'(stage_reset), 32'b110);
            23: chk("s1_stage1", 32'(stage_reset), 32'b100);
            26: chk("s1_stage2", obs_vec(), exp_vec(1'b1, 3'b000, 1'b0, 0, 0));
            27: chk("s1_locked", 32'(locked), 32'd1);
            default: ;
         endcase
      end

      // 3: one-cycle lock glitch during STABLE
      pll_lock = 1'b1;
      do_reset();
      for (int e = 1; e <= 26; e++) begin
         if (e == 8) pll_lock = 1'b0;
         if (e == 9) pll_lock = 1'b1;
         tick();
         case (e)
            13: chk("s3_no_early", 32'(stage_reset), 32'b111);
            18: chk("s3_hold_111", 32'(stage_reset), 32'b111);
            19: chk("s3_stage0", obs_vec(), exp_vec(1'b1, 3'b110, 1'b0, 0, 0));
            25: chk("s3_all_clear", 32'(stage_reset), 32'b000);
            26: chk("s3_locked", 32'(locked), 32'd1);
            default: ;
         endcase
      end

      // 4: lock loss in RUN
      pll_lock = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         if (stage_reset == 3'b111 && !locked) begin found = 1'b1; break; end
      end
      chk("s4_drop_resp", 32'(found), 32'd1);
      chk("s4_lost", obs_vec(), exp_vec(1'b0, 3'b111, 1'b0, 0, 1));
      pll_lock = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (locked) begin found = 1'b1; break; end
      end
      chk("s4_relock", 32'(found), 32'd1);

      // 5: relock_req in RUN, then in RESET_PLL
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      chk("s5_relock_run", obs_vec(), exp_vec(1'b0, 3'b111, 1'b0, 0, 1));
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      tick();
      tick();
      chk("s5_ignore_low", 32'(pll_resetb), 32'd0);
      tick();
      chk("s5_ignore_high", 32'(pll_resetb), 32'd1);
      found = 1'b0;
      for (int k = 0; k < 60; k++) begin
         tick();
         if (locked) begin found = 1'b1; break; end
      end
      chk("s5_back_run", 32'(found), 32'd1);
      // relock_req coincident with the synchronised lock drop
      pll_lock = 1'b0;
      tick();
      tick();
      relock_req = 1'b1;
      tick();
      relock_req = 1'b0;
      chk("s5_simul", obs_vec(), exp_vec(1'b0, 3'b111, 1'b0, 0, 2));
      tick();
      tick();
      tick();
      chk("s5_single_low", 32'(pll_resetb), 32'd0);
      tick();
      chk("s5_single_high", 32'(pll_resetb), 32'd1);

      // 6: reset during RELEASE
      pll_lock = 1'b1;
      found = 1'b0;
      for (int k = 0; k < 80; k++) begin
         tick();
         if (stage_reset == 3'b110) begin found = 1'b1; break; end
      end
      chk("s6_reach_release", 32'(found), 32'd1);
      tick();
      reset = 1'b1;
      tick();
      chk("s6_reset_mid", obs_vec(), exp_vec(1'b0, 3'b111, 1'b0, 0, 0));
      reset = 1'b0;

      // randomized lock activity and relock pulses
      for (int seg = 0; seg < 150; seg++) begin
         int n;
         pll_lock = ($urandom_range(0, 3) != 0);
         n = $urandom_range(1, 40);
         for (int k = 0; k < n; k++) begin
            relock_req = ($urandom_range(0, 60) == 0);
            tick();
         end
      end
      relock_req = 1'b0;

      // 2: lock never rises, retry count and saturation
      pll_lock = 1'b0;
      do_reset();
      for (int e = 1; e <= 54; e++) begin
         tick();
         if (e == 53) chk("s2_before_to", obs_vec(), exp_vec(1'b1, 3'b111, 1'b0, 0, 0));
         if (e == 54) chk("s2_timeout", obs_vec(), exp_vec(1'b0, 3'b111, 1'b0, 1, 0));
      end
      for (int k = 0; k < 256 * (PR + TO); k++) tick();
      chk("s2_saturate", 32'(retry_count), 32'd255);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
